// File: rtl/fetch_unit_pkg.sv
// Shared pipeline constants for the fetch stage: opcode encodings, the NOP
// used to fill a killed IF/ID slot, predictor counter reset value, and the
// control-flow classifier and counter update helpers.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0]      OP_BRANCH = 7'b1100011;
  localparam logic [6:0]      OP_JAL    = 7'b1101111;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [1:0]      CTR_RESET = 2'b01;   // weakly not-taken

  typedef enum logic [1:0] {
    CF_NONE,
    CF_BRANCH,
    CF_JAL
  } cf_kind_e;

  // Classify a fetched instruction by its opcode field.
  function automatic cf_kind_e cf_kind(input logic [6:0] opcode);
    cf_kind_e kind;
    kind = CF_NONE;
    if (opcode == OP_BRANCH) kind = CF_BRANCH;
    else if (opcode == OP_JAL) kind = CF_JAL;
    return kind;
  endfunction

  // Two-bit saturating counter step: never wraps past 2'b11 or 2'b00.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: the instruction-memory port and the IF/ID register
// contents handed to decode. The fetch unit is the master.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_instr;
  logic            if_id_valid;
  logic            if_id_pred_taken;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output if_id_pc,
    output if_id_instr,
    output if_id_valid,
    output if_id_pred_taken
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  if_id_pc,
    input  if_id_instr,
    input  if_id_valid,
    input  if_id_pred_taken
  );

endinterface

// File: rtl/fetch_bht.sv
// Branch history table: ENTRIES two-bit saturating counters. Lookup is
// combinational from the stored table, so a lookup that hits the entry
// being trained in the same cycle sees the pre-update counter.
module fetch_bht
  import fetch_unit_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [ENTRIES];

  // Predict taken for the upper half of the counter range.
  assign lookup_taken = (ctr_q[lookup_idx] >= 2'b10);

  // Train one counter per resolved branch; reset restarts all weakly not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every entry is reset because prediction must start from a known
      // weakly not-taken state; that keeps this table in flops, not a RAM.
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (upd_valid) begin
      ctr_q[upd_idx] <= sat_update(ctr_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, static JAL / dynamic branch
// prediction, and the IF/ID pipeline register.
// Build option: define FETCH_BHT_EN to include the fetch_bht counter table;
// without it every conditional branch is predicted not taken.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            ex_br_valid,
  input  logic [XLEN-1:0] ex_br_pc,
  input  logic            ex_br_taken,
  fetch_unit_if.master    bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] target;
  cf_kind_e        kind;
  logic            bht_taken;
  logic            pred_taken;

  assign bus.imem_addr = pc_q;
  assign instr         = bus.imem_rdata;
  assign kind          = cf_kind(instr[6:0]);

  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign target = pc_q + ((kind == CF_JAL) ? imm_j : imm_b);

`ifdef FETCH_BHT_EN
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  fetch_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk          (clk),
    .rst          (rst),
    .lookup_idx   (pc_q[IDX_W+1:2]),
    .lookup_taken (bht_taken),
    .upd_valid    (ex_br_valid),
    .upd_idx      (ex_br_pc[IDX_W+1:2]),
    .upd_taken    (ex_br_taken)
  );

  // Only the word-index bits of the resolved branch PC select a counter.
  logic unused_br_pc_bits;
  assign unused_br_pc_bits = ^{ex_br_pc[XLEN-1:IDX_W+2], ex_br_pc[1:0]};
`else
  assign bht_taken = 1'b0;

  // Branch-resolution inputs and the table size have no consumer in this build.
  logic unused_cfg;
  assign unused_cfg = (^{ex_br_valid, ex_br_pc, ex_br_taken}) ^ (BHT_ENTRIES > 0);
`endif

  assign pred_taken = (kind == CF_JAL) || ((kind == CF_BRANCH) && bht_taken);

  // Next-PC selection: flush beats stall, stall beats prediction.
  always_comb begin
    // NOTE: pc_next is given a default before the priority chain so every
    // path assigns it and no latch is inferred.
    pc_next = pc_q + 32'd4;
    if (flush)           pc_next = redirect_pc;
    else if (!pc_write)  pc_next = pc_q;
    else if (pred_taken) pc_next = target;
  end

  // PC register; reset overrides flush and stall.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_next;
  end

  // IF/ID register: reset and flush insert a NOP bubble, stall holds.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      bus.if_id_pc         <= '0;
      bus.if_id_instr      <= NOP_INSTR;
      bus.if_id_valid      <= 1'b0;
      bus.if_id_pred_taken <= 1'b0;
    end else if (if_id_write) begin
      bus.if_id_pc         <= pc_q;
      bus.if_id_instr      <= instr;
      bus.if_id_valid      <= 1'b1;
      bus.if_id_pred_taken <= pred_taken;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A word-level reference model tracks the
// expected PC, IF/ID contents and predictor counters from the instruction kind
// and offset the bench itself placed in memory.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          BHT    = 64;
`ifdef FETCH_BHT_EN
  localparam bit BHT_EN = 1'b1;
`else
  localparam bit BHT_EN = 1'b0;
`endif
  localparam int K_OTHER = 0;
  localparam int K_BR    = 1;
  localparam int K_JAL   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        if_id_write;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        ex_br_valid;
  logic [31:0] ex_br_pc;
  logic        ex_br_taken;

  int checks = 0;
  int errors = 0;

  // Instruction memory (4 KiB, aliased) plus what the bench put in each word.
  logic [31:0] mem  [1024];
  int          kind [1024];
  int          offs [1024];

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifinstr;
  logic        m_ifvalid;
  logic        m_ifpred;
  int          ctr [BHT];

  fetch_unit_if bus ();

  assign bus.imem_rdata = mem[bus.imem_addr[11:2]];

  fetch_unit #(.RESET_PC(RST_PC), .BHT_ENTRIES(BHT)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .ex_br_valid (ex_br_valid),
    .ex_br_pc    (ex_br_pc),
    .ex_br_taken (ex_br_taken),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_branch(input int off);
    logic [31:0] o;
    o = off;
    return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int off);
    logic [31:0] o;
    o = off;
    return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_alu();
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], 7'b0010011};
  endfunction

  task automatic put(input logic [31:0] addr, input int k, input int off);
    int i;
    i = int'(addr[11:2]);
    kind[i] = k;
    offs[i] = off;
    if (k == K_BR)       mem[i] = enc_branch(off);
    else if (k == K_JAL) mem[i] = enc_jal(off);
    else                 mem[i] = enc_alu();
  endtask

  task automatic fill_alu();
    for (int i = 0; i < 1024; i++) put(32'(i * 4), K_OTHER, 0);
  endtask

  function automatic logic [97:0] obs_vec();
    return {bus.imem_addr, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.if_id_pred_taken};
  endfunction

  function automatic logic [97:0] exp_vec();
    return {m_pc, m_ifpc, m_ifinstr, m_ifvalid, m_ifpred};
  endfunction

  // Drive one cycle of inputs, clock it, and advance the reference model.
  task automatic step(input bit r, input bit f, input logic [31:0] rp, input bit pw,
                      input bit iw, input bit bv, input logic [31:0] bpc, input bit bt);
    int  i;
    int  li;
    int  bi;
    bit  pred;
    logic [31:0] cur;
    rst = r; flush = f; redirect_pc = rp; pc_write = pw; if_id_write = iw;
    ex_br_valid = bv; ex_br_pc = bpc; ex_br_taken = bt;
    cur  = m_pc;
    i    = int'(cur[11:2]);
    li   = int'(cur[31:2]) % BHT;
    pred = (kind[i] == K_JAL) || (kind[i] == K_BR && BHT_EN && ctr[li] >= 2);
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = RST_PC; m_ifpc = 0; m_ifinstr = 32'h0000_0013; m_ifvalid = 0; m_ifpred = 0;
      for (int k = 0; k < BHT; k++) ctr[k] = 1;
    end else begin
      if (f) begin
        m_ifpc = 0; m_ifinstr = 32'h0000_0013; m_ifvalid = 0; m_ifpred = 0;
      end else if (iw) begin
        m_ifpc = cur; m_ifinstr = mem[i]; m_ifvalid = 1; m_ifpred = pred;
      end
      if (f)         m_pc = rp;
      else if (!pw)  m_pc = cur;
      else if (pred) m_pc = cur + 32'(offs[i]);
      else           m_pc = cur + 32'd4;
      if (BHT_EN && bv) begin
        bi = int'(bpc[31:2]) % BHT;
        if (bt) ctr[bi] = (ctr[bi] == 3) ? 3 : ctr[bi] + 1;
        else    ctr[bi] = (ctr[bi] == 0) ? 0 : ctr[bi] - 1;
      end
    end
  endtask

  task automatic run(input logic [31:0] pw_iw_flag);
    step(0, 0, 0, pw_iw_flag[0], pw_iw_flag[0], 0, 0, 0);
  endtask

  task automatic test_reset();
    fill_alu();
    step(1, 1, 32'h0000_0800, 0, 0, 0, 0, 0);
    checks++;
    if (bus.imem_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL reset_pc: got %h expected 00000100", bus.imem_addr);
    end
    checks++;
    if (bus.if_id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.if_id_valid);
    end
    checks++;
    if (bus.if_id_instr !== 32'h0000_0013) begin
      errors++; $display("FAIL reset_instr: got %h expected 00000013", bus.if_id_instr);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_sequential_stall();
    step(0, 1, 32'h0, 1, 1, 0, 0, 0);          // redirect to ADDI stream at 0x0
    run(1);                                    // fetch 0x0
    run(1);                                    // fetch 0x4, PC -> 0x8
    checks++;
    if (bus.imem_addr !== 32'h8 || bus.if_id_pc !== 32'h4) begin
      errors++; $display("FAIL seq_pre_stall: got pc %h ifpc %h expected 00000008 00000004",
                         bus.imem_addr, bus.if_id_pc);
    end
    run(0);                                    // one-cycle stall
    checks++;
    if (bus.imem_addr !== 32'h8 || bus.if_id_pc !== 32'h4) begin
      errors++; $display("FAIL seq_stall_hold: got pc %h ifpc %h expected 00000008 00000004",
                         bus.imem_addr, bus.if_id_pc);
    end
    run(1);
    checks++;
    if (bus.imem_addr !== 32'hC || bus.if_id_pc !== 32'h8 || bus.if_id_valid !== 1'b1) begin
      errors++; $display("FAIL seq_resume: got pc %h ifpc %h v %b expected 0000000c 00000008 1",
                         bus.imem_addr, bus.if_id_pc, bus.if_id_valid);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL seq_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_jal();
    put(32'h20, K_JAL, 256);
    step(0, 1, 32'h20, 1, 1, 0, 0, 0);
    run(1);
    checks++;
    if (bus.imem_addr !== 32'h120 || bus.if_id_pred_taken !== 1'b1 || bus.if_id_pc !== 32'h20) begin
      errors++; $display("FAIL jal: got pc %h pred %b ifpc %h expected 00000120 1 00000020",
                         bus.imem_addr, bus.if_id_pred_taken, bus.if_id_pc);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL jal_model: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_flush_vs_stall();
    run(1);
    step(0, 1, 32'h400, 0, 0, 0, 0, 0);
    checks++;
    if (bus.imem_addr !== 32'h400 || bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h13) begin
      errors++; $display("FAIL flush_vs_stall: got pc %h v %b instr %h expected 00000400 0 00000013",
                         bus.imem_addr, bus.if_id_valid, bus.if_id_instr);
    end
  endtask

  task automatic test_bht_training();
    logic [31:0] want;
    fill_alu();
    step(1, 0, 0, 1, 1, 0, 0, 0);
    put(32'h40, K_BR, 16);
    run(1);                                    // fetch at 0x100 before the branch is trained
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL bht_untrained_model: got %h expected %h", obs_vec(), exp_vec());
    end
    step(0, 0, 0, 0, 0, 1, 32'h40, 1);
    step(0, 0, 0, 0, 0, 1, 32'h40, 1);
    step(0, 1, 32'h40, 1, 1, 0, 0, 0);
    run(1);
    want = BHT_EN ? 32'h50 : 32'h44;
    checks++;
    if (bus.imem_addr !== want || bus.if_id_pred_taken !== BHT_EN) begin
      errors++; $display("FAIL bht_training: got pc %h pred %b expected %h %b",
                         bus.imem_addr, bus.if_id_pred_taken, want, BHT_EN);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] want;
    fill_alu();
    step(1, 0, 0, 1, 1, 0, 0, 0);
    put(32'h60, K_BR, -32);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 1, 32'h60, 1);
    step(0, 0, 0, 0, 0, 1, 32'h60, 0);
    step(0, 1, 32'h60, 1, 1, 0, 0, 0);
    run(1);
    want = BHT_EN ? 32'h40 : 32'h64;
    checks++;
    if (bus.imem_addr !== want || bus.if_id_pred_taken !== BHT_EN) begin
      errors++; $display("FAIL saturation: got pc %h pred %b expected %h %b",
                         bus.imem_addr, bus.if_id_pred_taken, want, BHT_EN);
    end
  endtask

  task automatic test_random();
    int roll;
    bit r, f, pw, iw, bv, bt;
    logic [31:0] rp, bpc;
    for (int i = 0; i < 1024; i++) begin
      roll = int'($urandom_range(0, 9));
      if (roll < 2)       put(32'(i * 4), K_BR,  (int'($urandom_range(0, 64)) - 32) * 4);
      else if (roll == 2) put(32'(i * 4), K_JAL, (int'($urandom_range(0, 64)) - 32) * 8);
      else                put(32'(i * 4), K_OTHER, 0);
    end
    step(1, 0, 0, 1, 1, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 149) == 0);
      f   = ($urandom_range(0, 15) == 0);
      rp  = 32'($urandom_range(0, 1023)) << 2;
      pw  = ($urandom_range(0, 7) != 0);
      iw  = ($urandom_range(0, 7) != 0);
      bv  = ($urandom_range(0, 1) == 1);
      bpc = ($urandom_range(0, 2) == 0) ? m_pc : (32'($urandom_range(0, 15)) << 2) + 32'h40;
      bt  = ($urandom_range(0, 2) != 0);
      step(r, f, rp, pw, iw, bv, bpc, bt);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle_%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; redirect_pc = '0; pc_write = 1'b0; if_id_write = 1'b0;
    ex_br_valid = 1'b0; ex_br_pc = '0; ex_br_taken = 1'b0;
    m_pc = '0; m_ifpc = '0; m_ifinstr = '0; m_ifvalid = 1'b0; m_ifpred = 1'b0;
    for (int k = 0; k < BHT; k++) ctr[k] = 1;
    test_reset();
    test_sequential_stall();
    test_jal();
    test_flush_vs_stall();
    test_bht_training();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
